// File: rtl/sram_bus_arbiter.sv
// Arbitrates one write port and READER_COUNT round-robin read ports onto a
// single-port SRAM with 1-cycle read latency; writes always win the bus.
module sram_bus_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 14,
    parameter int DATA_WIDTH        = 16,
    parameter int READER_COUNT      = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ADDRESS_BUS_WIDTH-1:0]           write_address,
    input  logic [DATA_WIDTH-1:0]                  write_data,
    input  logic                                   write_strobe,
    input  logic [READER_COUNT*ADDRESS_BUS_WIDTH-1:0] read_address,
    input  logic [READER_COUNT-1:0]                read_strobe,
    output logic [DATA_WIDTH-1:0]                  read_data,
    output logic [READER_COUNT-1:0]                read_finished_strobe,
    output logic [READER_COUNT-1:0]                request_overrun,
    output logic [1:0]                             state,
    output logic [ADDRESS_BUS_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]                  mem_write_data,
    output logic                                   mem_write_enable,
    input  logic [DATA_WIDTH-1:0]                  mem_read_data
);

    localparam int PTR_WIDTH = (READER_COUNT > 1) ? $clog2(READER_COUNT) : 1;
    localparam logic [PTR_WIDTH-1:0] PTR_RESET = PTR_WIDTH'(READER_COUNT - 1);

    localparam logic [1:0] STATE_IDLE  = 2'b00;
    localparam logic [1:0] STATE_READ  = 2'b01;
    localparam logic [1:0] STATE_WRITE = 2'b10;

    logic                         write_pending;
    logic [ADDRESS_BUS_WIDTH-1:0] write_addr_reg;
    logic [DATA_WIDTH-1:0]        write_data_reg;
    logic [READER_COUNT-1:0]      pending;
    logic [ADDRESS_BUS_WIDTH-1:0] addr_reg [READER_COUNT];
    logic [PTR_WIDTH-1:0]         rr_ptr;

    logic                         issue_valid;
    logic [PTR_WIDTH-1:0]         issue_tag;
    logic                         data_valid;
    logic [PTR_WIDTH-1:0]         data_tag;

    logic [READER_COUNT-1:0]      request;
    logic                         grant_found;
    logic [PTR_WIDTH-1:0]         grant_index;
    logic [ADDRESS_BUS_WIDTH-1:0] grant_address;
    logic                         read_issue;
    logic [READER_COUNT-1:0]      finish_onehot;

    // Same-cycle strobes join the request set so an idle bus issues next edge.
    always_comb begin
        int                   candidate;
        logic [PTR_WIDTH-1:0] cand_idx;
        request     = pending | read_strobe;
        grant_found = 1'b0;
        grant_index = '0;
        candidate   = 0;
        cand_idx    = '0;
        for (int k = 1; k <= READER_COUNT; k++) begin
            candidate = int'(rr_ptr) + k;
            if (candidate >= READER_COUNT)
                candidate = candidate - READER_COUNT;
            cand_idx = PTR_WIDTH'(candidate);
            if (!grant_found && request[cand_idx]) begin
                grant_found = 1'b1;
                grant_index = cand_idx;
            end
        end
    end

    // An already-pending request is served from its register; a fresh one bypasses.
    always_comb begin
        if (pending[grant_index])
            grant_address = addr_reg[grant_index];
        else
            grant_address = read_address[int'(grant_index)*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
        read_issue = grant_found && !write_pending && !write_strobe;
    end

    always_comb begin
        finish_onehot           = '0;
        finish_onehot[data_tag] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_pending        <= 1'b0;
            write_addr_reg       <= '0;
            write_data_reg       <= '0;
            pending              <= '0;
            rr_ptr               <= PTR_RESET;
            issue_valid          <= 1'b0;
            issue_tag            <= '0;
            data_valid           <= 1'b0;
            data_tag             <= '0;
            read_data            <= '0;
            read_finished_strobe <= '0;
            request_overrun      <= '0;
            state                <= STATE_IDLE;
            mem_address          <= '0;
            mem_write_data       <= '0;
            mem_write_enable     <= 1'b0;
            for (int i = 0; i < READER_COUNT; i++)
                addr_reg[i] <= '0;
        end else begin
            if (write_pending) begin
                mem_address      <= write_addr_reg;
                mem_write_data   <= write_data_reg;
                mem_write_enable <= 1'b1;
                state            <= STATE_WRITE;
                write_pending    <= write_strobe;
                if (write_strobe) begin
                    write_addr_reg <= write_address;
                    write_data_reg <= write_data;
                end
            end else if (write_strobe) begin
                mem_address      <= write_address;
                mem_write_data   <= write_data;
                mem_write_enable <= 1'b1;
                state            <= STATE_WRITE;
            end else if (grant_found) begin
                mem_address      <= grant_address;
                mem_write_enable <= 1'b0;
                state            <= STATE_READ;
            end else begin
                mem_write_enable <= 1'b0;
                state            <= STATE_IDLE;
            end

            if (read_issue)
                rr_ptr <= grant_index;

            issue_valid <= read_issue;
            issue_tag   <= grant_index;
            data_valid  <= issue_valid;
            data_tag    <= issue_tag;

            read_finished_strobe <= data_valid ? finish_onehot : '0;
            if (data_valid)
                read_data <= mem_read_data;

            // A strobe arriving as the old request is granted becomes the next request.
            for (int i = 0; i < READER_COUNT; i++) begin
                if (read_strobe[i])
                    addr_reg[i] <= read_address[i*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
                if (read_issue && grant_index == PTR_WIDTH'(i)) begin
                    pending[i] <= pending[i] & read_strobe[i];
                end else begin
                    pending[i] <= pending[i] | read_strobe[i];
                    if (pending[i] && read_strobe[i])
                        request_overrun[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: cycle-exact bus checks plus a read
// scoreboard fed from a reference copy of memory.
module tb_sram_bus_arbiter;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int RC = 4;

    typedef struct packed {
        logic [RC-1:0] strobe;
        logic [DW-1:0] data;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     write_address;
    logic [DW-1:0]     write_data;
    logic              write_strobe;
    logic [RC*AW-1:0]  read_address;
    logic [RC-1:0]     read_strobe;
    logic [DW-1:0]     read_data;
    logic [RC-1:0]     read_finished_strobe;
    logic [RC-1:0]     request_overrun;
    logic [1:0]        state;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_write_data;
    logic              mem_write_enable;
    logic [DW-1:0]     mem_read_data;

    logic [DW-1:0]     sram    [0:63];
    logic [DW-1:0]     ref_mem [0:63];
    exp_t              sb [$];
    int                vectors;
    int                miscompares;

    sram_bus_arbiter #(
        .ADDRESS_BUS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .READER_COUNT(RC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .write_address(write_address),
        .write_data(write_data),
        .write_strobe(write_strobe),
        .read_address(read_address),
        .read_strobe(read_strobe),
        .read_data(read_data),
        .read_finished_strobe(read_finished_strobe),
        .request_overrun(request_overrun),
        .state(state),
        .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM model, read-before-write, 1-cycle latency.
    always @(posedge clk) begin
        if (mem_write_enable)
            sram[mem_address[5:0]] <= mem_write_data;
        mem_read_data <= sram[mem_address[5:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ws, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [RC-1:0] rs, input logic [RC*AW-1:0] ra);
        write_strobe  = ws;
        write_address = wa;
        write_data    = wd;
        read_strobe   = rs;
        read_address  = ra;
        if (ws)
            ref_mem[wa[5:0]] = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        write_strobe = 1'b0;
        read_strobe  = '0;
    endtask

    function automatic logic [RC*AW-1:0] pack_addr(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    task automatic expectRead(input int reader, input int addr);
        exp_t e;
        e.strobe = 4'b0001 << reader;
        e.data   = ref_mem[addr];
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++)
            step();
        checkOutput("drain_timeout", sb.size(), 0);
    endtask

    task automatic checkBus(input string tag, input logic [1:0] st, input logic we, input int addr);
        checkOutput({tag, "_state"}, state, st);
        checkOutput({tag, "_we"}, mem_write_enable, we);
        checkOutput({tag, "_addr"}, mem_address, addr);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_state"}, state, 2'b00);
        checkOutput({tag, "_we"}, mem_write_enable, 1'b0);
        checkOutput({tag, "_addr"}, mem_address, 0);
        checkOutput({tag, "_wdata"}, mem_write_data, 0);
        checkOutput({tag, "_rdata"}, read_data, 0);
        checkOutput({tag, "_finished"}, read_finished_strobe, 0);
        checkOutput({tag, "_overrun"}, request_overrun, 0);
    endtask

    // Every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (read_finished_strobe !== '0) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_finish", read_finished_strobe, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("finish_strobe", read_finished_strobe, e.strobe);
                checkOutput("finish_data", read_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int a = 0; a < 64; a++) begin
            sram[a]    = 16'hA000 | 16'(a);
            ref_mem[a] = 16'hA000 | 16'(a);
        end
        sram[7]    = 16'hBEEF;
        ref_mem[7] = 16'hBEEF;

        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkReset("reset");

        // All readers at once, twice: round-robin from reader 0 both times.
        applyStimulus(1'b0, '0, '0, 4'hF, pack_addr(16, 17, 18, 19));
        for (int r = 0; r < RC; r++) expectRead(r, 16 + r);
        for (int r = 0; r < RC; r++) begin
            step();
            checkBus("rr1", 2'b01, 1'b0, 16 + r);
        end
        step();
        checkOutput("rr_gap_state", state, 2'b00);
        applyStimulus(1'b0, '0, '0, 4'hF, pack_addr(32, 33, 34, 35));
        for (int r = 0; r < RC; r++) expectRead(r, 32 + r);
        for (int r = 0; r < RC; r++) begin
            step();
            checkBus("rr2", 2'b01, 1'b0, 32 + r);
        end
        drain();
        checkOutput("rr_no_overrun", request_overrun, 0);

        // Single write.
        step();
        applyStimulus(1'b1, AW'(5), 16'h1234, '0, '0);
        step();
        checkBus("write", 2'b10, 1'b1, 5);
        checkOutput("write_data", mem_write_data, 16'h1234);
        step();
        checkBus("write_after", 2'b00, 1'b0, 5);

        // Reader 2 read on idle bus: finished three cycles after the strobe.
        applyStimulus(1'b0, '0, '0, 4'b0100, pack_addr(0, 0, 7, 0));
        expectRead(2, 7);
        step();
        checkBus("read_issue", 2'b01, 1'b0, 7);
        step();
        checkOutput("read_n2_finished", read_finished_strobe, 4'b0000);
        step();
        checkOutput("read_n3_finished", read_finished_strobe, 4'b0100);
        checkOutput("read_n3_data", read_data, 16'hBEEF);
        drain();

        // Back-to-back writes starve reader 1 until the write burst ends.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, AW'(40 + k), 16'h5000 + 16'(k),
                          (k == 0) ? 4'b0010 : 4'b0000, pack_addr(0, 40, 0, 0));
            if (k == 0) expectRead(1, 40);
            step();
            checkBus("burst_write", 2'b10, 1'b1, 40 + k);
        end
        step();
        checkBus("burst_read", 2'b01, 1'b0, 40);
        step();
        checkOutput("burst_n6_finished", read_finished_strobe, 4'b0000);
        step();
        checkOutput("burst_n7_finished", read_finished_strobe, 4'b0010);
        checkOutput("burst_n7_data", read_data, 16'h5000);
        drain();

        // Re-strobe while the write holds the bus: overrun, newest address wins.
        applyStimulus(1'b1, AW'(50), 16'h6000, 4'b0001, pack_addr(3, 0, 0, 0));
        step();
        checkBus("ovr_w0", 2'b10, 1'b1, 50);
        checkOutput("ovr_before", request_overrun, 4'b0000);
        applyStimulus(1'b1, AW'(51), 16'h6001, 4'b0001, pack_addr(9, 0, 0, 0));
        expectRead(0, 9);
        step();
        checkBus("ovr_w1", 2'b10, 1'b1, 51);
        checkOutput("ovr_set", request_overrun, 4'b0001);
        step();
        checkBus("ovr_read", 2'b01, 1'b0, 9);
        drain();
        repeat (4) step();
        checkOutput("ovr_sticky", request_overrun, 4'b0001);

        // Reset one cycle after a read issues: the in-flight read vanishes.
        applyStimulus(1'b0, '0, '0, 4'b1000, pack_addr(0, 0, 0, 10));
        step();
        checkBus("rst_issue", 2'b01, 1'b0, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkReset("midreset");
        repeat (5) step();
        checkOutput("midreset_queue", sb.size(), 0);

        // Reader 3 re-requests after reset and is served normally.
        applyStimulus(1'b0, '0, '0, 4'b1000, pack_addr(0, 0, 0, 10));
        expectRead(3, 10);
        step();
        checkBus("rerequest", 2'b01, 1'b0, 10);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
